// File: rtl/video_pkg.sv
// Shared types for the video pattern generator: pattern modes,
// FSM states, the 24-bit rgb type and the colour-bar table.
package video_pkg;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pat_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } gen_state_e;

  localparam rgb_t BAR_TABLE [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/video_timing_cnt.sv
// Horizontal/vertical raster counters with active, sync and
// end-of-line / end-of-frame decode (unregistered, raw polarity).
module video_timing_cnt
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int HW       = 11,
  parameter int VW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_run,
  output logic [HW-1:0] o_hcnt,
  output logic [VW-1:0] o_vcnt,
  output logic          o_active,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_line_end,
  output logic          o_frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic [31:0]   w_h32;
  logic [31:0]   w_v32;

  assign w_h32 = 32'(r_hcnt);
  assign w_v32 = 32'(r_vcnt);

  assign o_line_end  = (r_hcnt == HW'(H_TOTAL - 1));
  assign o_frame_end = o_line_end && (r_vcnt == VW'(V_TOTAL - 1));

  // Counters sit at the origin whenever the generator is idle
  always_ff @(posedge clk) begin
    if (reset || !i_run) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (o_line_end) begin
      r_hcnt <= '0;
      r_vcnt <= o_frame_end ? '0 : r_vcnt + 1'b1;
    end else begin
      r_hcnt <= r_hcnt + 1'b1;
    end
  end

  assign o_hcnt   = r_hcnt;
  assign o_vcnt   = r_vcnt;
  assign o_active = (w_h32 < H_ACTIVE) && (w_v32 < V_ACTIVE);
  assign o_hsync  = (w_h32 >= HS_BEG) && (w_h32 < HS_END);
  assign o_vsync  = (w_v32 >= VS_BEG) && (w_v32 < VS_END);

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern video source: bars, ramp, checker, solid.
// Define VIDEO_PATGEN_MOVE_EN to scroll ramp/checker once per frame.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  output logic        active_pixel,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic        frame_done
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BW      = $clog2(BAR_W + 1);

  gen_state_e    r_state;
  gen_state_e    w_state_nxt;
  pat_mode_e     r_mode;
  rgb_t          r_solid;
  rgb_t          w_pix;
  logic [BW-1:0] r_bar_cnt;
  logic [2:0]    r_bar_idx;
  logic [7:0]    w_fofs;
  logic [7:0]    w_hsum;
  logic          w_vbit5;
  logic          w_run;
  logic          w_live;

  logic [HW-1:0] w_hcnt;
  logic [VW-1:0] w_vcnt;
  logic          w_active;
  logic          w_hs;
  logic          w_vs;
  logic          w_line_end;
  logic          w_frame_end;

  video_timing_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .i_run       (w_run),
    .o_hcnt      (w_hcnt),
    .o_vcnt      (w_vcnt),
    .o_active    (w_active),
    .o_hsync     (w_hs),
    .o_vsync     (w_vs),
    .o_line_end  (w_line_end),
    .o_frame_end (w_frame_end)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (enable) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (!enable)
          w_state_nxt = w_frame_end ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_frame_end)
          w_state_nxt = enable ? ST_RUN : ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_run  = (r_state != ST_IDLE);
  assign w_live = w_run && w_active;

  // Pattern settings are captured only as the raster re-enters (0,0)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode  <= PAT_BARS;
      r_solid <= '0;
    end else if (!w_run || w_frame_end) begin
      r_mode  <= pat_mode_e'(mode);
      r_solid <= solid_rgb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !w_run || w_line_end) begin
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
    end else if (r_bar_cnt == BW'(BAR_W - 1)) begin
      r_bar_cnt <= '0;
      r_bar_idx <= r_bar_idx + 3'd1;
    end else begin
      r_bar_cnt <= r_bar_cnt + 1'b1;
    end
  end

`ifdef VIDEO_PATGEN_MOVE_EN
  logic [7:0] r_fcnt;

  always_ff @(posedge clk) begin
    if (reset)                   r_fcnt <= '0;
    else if (w_run && w_frame_end) r_fcnt <= r_fcnt + 8'd1;
  end

  assign w_fofs = r_fcnt;
`else
  assign w_fofs = 8'd0;
`endif

  assign w_hsum  = 8'(w_hcnt) + w_fofs;
  assign w_vbit5 = |(32'(w_vcnt) & 32'd32);

  always_comb begin
    w_pix = '0;
    unique case (1'b1)
      (r_mode == PAT_BARS):  w_pix = BAR_TABLE[r_bar_idx];
      (r_mode == PAT_RAMP):  w_pix = {3{w_hsum}};
      (r_mode == PAT_CHECK): w_pix = (w_hsum[5] ^ w_vbit5) ? 24'hFFFFFF : 24'h0;
      default:               w_pix = r_solid;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_pixel <= 1'b0;
      hsync_out    <= ~SYNC_POL;
      vsync_out    <= ~SYNC_POL;
      r_out        <= '0;
      g_out        <= '0;
      b_out        <= '0;
      frame_done   <= 1'b0;
    end else begin
      active_pixel <= w_live;
      hsync_out    <= (w_run && w_hs) ^ ~SYNC_POL;
      vsync_out    <= (w_run && w_vs) ^ ~SYNC_POL;
      {r_out, g_out, b_out} <= w_live ? w_pix : 24'h0;
      frame_done   <= w_run && w_frame_end;
    end
  end

endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280, meaning active pixels per line; must be a multiple of 8.
REQ-002 SHALL have parameters H_FP 110, H_SYNC 40, H_BP 220, meaning horizontal porch and sync widths in clocks.
REQ-003 SHALL have parameters V_ACTIVE 720, V_FP 5, V_SYNC 5, V_BP 20, meaning vertical geometry in lines.
REQ-004 SHALL have parameter SYNC_POL, default 1, meaning 1 = syncs active-high and 0 = active-low.
REQ-005 SHALL have port clk, input, 1 bit, pixel clock; single clock domain.
REQ-006 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port enable, input, 1 bit, start/continue generation.
REQ-008 SHALL have port mode, input, 2 bits, pattern select: 0 bars, 1 ramp, 2 checker, 3 solid.
REQ-009 SHALL have port solid_rgb, input, 24 bits, colour {r,g,b} used by mode 3.
REQ-010 SHALL have ports active_pixel, hsync_out and vsync_out, outputs, 1 bit each, stream timing in the same format the video filter consumes.
REQ-011 SHALL have ports r_out, g_out and b_out, outputs, 8 bits each, pixel data.
REQ-012 SHALL have port frame_done, output, 1 bit, one-clock pulse on the last clock of each frame.

Function
REQ-013 Counters: hcnt 0..H_TOTAL-1, vcnt 0..V_TOTAL-1.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- hcnt wraps to 0 and increments vcnt.
- vcnt wraps to 0 after V_TOTAL-1.
REQ-014 FSM states and transitions:
- IDLE -> RUN when enable=1; counters start at (0,0) on the next clock.
- RUN -> DRAIN when enable=0 mid-frame.
- DRAIN -> IDLE at the end of the frame (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1).
- DRAIN -> RUN at the end of the frame if enable has returned to 1.
REQ-015 active_pixel = (hcnt<H_ACTIVE)&&(vcnt<V_ACTIVE), asserted only in RUN or DRAIN.
REQ-016 hsync_out is asserted (per SYNC_POL) for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
REQ-017 vsync_out is asserted (per SYNC_POL) for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC, for all hcnt of those lines.
REQ-018 All outputs SHALL be registered with exactly 1 clock latency from counter state; timing and data are mutually aligned.
REQ-019 mode and solid_rgb SHALL be sampled only when entering frame position (0,0); mid-frame changes take effect next frame.
REQ-020 Mode 0 (colour bars): 8 bars of width H_ACTIVE/8 in the order white, yellow, cyan, green, magenta, red, blue, black (components 00/FF). The bar index SHALL come from a bar-width counter, not a divider.
REQ-021 Mode 1 (ramp): r=g=b=hcnt[7:0].
REQ-022 Mode 2 (checker): r=g=b = (hcnt[5]^vcnt[5]) ? FF : 00.
REQ-023 Mode 3 (solid): latched solid_rgb.
REQ-024 When active_pixel=0 (blanking, IDLE), r/g/b SHALL be 0.
REQ-025 In IDLE: syncs held at their inactive level, active_pixel=0, counters held at 0.
REQ-026 frame_done is asserted for one clock aligned with the output of position (H_TOTAL-1, V_TOTAL-1), including in DRAIN.

Reset
REQ-027 Reset applies at a clock edge and overrides enable:
- FSM goes to IDLE; hcnt=vcnt=0.
- active_pixel=0, frame_done=0, r/g/b=0.
- hsync_out and vsync_out at their inactive level (~SYNC_POL).
- Latched mode = 0.
REQ-028 Reset mid-frame SHALL abort the frame immediately with no frame_done.

Configuration
REQ-029 With VIDEO_PATGEN_MOVE_EN defined:
- An 8-bit frame counter increments at each frame_done and resets to 0.
- Mode 1 uses hcnt[7:0]+fcnt.
- Mode 2 uses (hcnt+fcnt)[5]^vcnt[5].
REQ-030 Without VIDEO_PATGEN_MOVE_EN: no frame counter is present and patterns are static.

Structure
REQ-031 Package video_pkg SHALL hold:
- the pattern mode enumeration (PAT_BARS, PAT_RAMP, PAT_CHECK, PAT_SOLID);
- the 8-entry bar colour table;
- a 24-bit rgb typedef.
REQ-032 Sub-module video_timing_cnt SHALL contain the h/v counters, active/sync decode and frame-end flag; the pattern datapath and FSM stay in the top.

Verification (bench parameters: H 16/2/3/3, H_TOTAL 24; V 4/1/1/1, V_TOTAL 7; SYNC_POL=1)
REQ-033 enable=1 from reset, mode 0:
- line 0 outputs FFFFFF for 2 clocks, then FFFF00, and so on through 000000.
- hsync_out high for exactly 3 clocks starting 18 clocks after the first active pixel.
REQ-034 Mode 2, 2 full frames:
- vsync_out high for exactly 24 clocks per frame.
- frame_done pulses every 168 clocks.
- active_pixel count = 64 per frame.
REQ-035 Mode change mid-frame (3 then 1):
- current frame stays solid_rgb.
- next frame's first pixel = 00, then 01.
REQ-036 enable dropped at vcnt=1: frame completes (frame_done pulses), then outputs idle with syncs low.
REQ-037 Reset asserted at hcnt=5, vcnt=2: next output cycle shows all outputs at reset values; no frame_done.
REQ-038 With VIDEO_PATGEN_MOVE_EN in mode 1: frame 2, pixel 0 = 01; without the macro = 00.
